// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and state encoding for the FIFO controller.
package fifo_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 10;
  localparam int unsigned DEF_MEM_SIZE   = 256;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE       = 2'd0;
  localparam logic [STATE_W-1:0] ST_RD_ISSUE   = 2'd1;
  localparam logic [STATE_W-1:0] ST_RD_CAPTURE = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = ST_IDLE,
    RD_ISSUE   = ST_RD_ISSUE,
    RD_CAPTURE = ST_RD_CAPTURE
  } state_e;

endpackage

// File: rtl/ptr_wrap.sv
// Memory pointer that counts 0..SIZE-1 and wraps back to 0.
module ptr_wrap
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned SIZE  = DEF_MEM_SIZE
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(SIZE - 1);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  // Next pointer: advance on request, wrap at the last entry.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + WIDTH'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller over a single-port synchronous RAM with a registered
// output stage. Reads take two cycles (issue, capture) and win over writes.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MEM_SIZE   = DEF_MEM_SIZE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PUSH_VALID,
  input  logic [DATA_WIDTH-1:0] PUSH_DATA,
  output logic                  PUSH_READY,
  output logic                  POP_VALID,
  output logic [DATA_WIDTH-1:0] POP_DATA,
  input  logic                  POP_READY,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_EN,
  output logic                  MEM_WE,
  output logic [DATA_WIDTH-1:0] MEM_DIN,
  input  logic [DATA_WIDTH-1:0] MEM_DOUT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_SIZE);

  state_e                  state_q;
  logic [CNT_W-1:0]        mem_cnt_q;
  logic                    pop_valid_q;
  logic [DATA_WIDTH-1:0]   pop_data_q;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;

  logic rd_start;
  logic push_ready;
  logic push_xfer;
  logic pop_xfer;
  logic capture;

  // Handshake decode; a pending read blocks the producer for that cycle.
  always_comb begin
    rd_start   = (state_q == IDLE) && (mem_cnt_q != '0) &&
                 (!pop_valid_q || POP_READY);
    push_ready = RST && (state_q == IDLE) && (mem_cnt_q < CNT_MAX) && !rd_start;
    push_xfer  = PUSH_VALID && push_ready;
    pop_xfer   = pop_valid_q && POP_READY;
    capture    = (state_q == RD_CAPTURE);
  end

  // Memory command: read address held through issue and capture.
  always_comb begin
    MEM_EN   = 1'b0;
    MEM_WE   = 1'b0;
    MEM_ADDR = '0;
    MEM_DIN  = '0;
    if (RST) begin
      if (state_q == RD_ISSUE || state_q == RD_CAPTURE) begin
        MEM_EN   = 1'b1;
        MEM_ADDR = rd_ptr;
      end else if (push_xfer) begin
        MEM_EN   = 1'b1;
        MEM_WE   = 1'b1;
        MEM_ADDR = wr_ptr;
        MEM_DIN  = PUSH_DATA;
      end
    end
  end

  // Read sequencer, occupancy count and output register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      mem_cnt_q   <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE:       if (rd_start) state_q <= RD_ISSUE;
        RD_ISSUE:   state_q <= RD_CAPTURE;
        RD_CAPTURE: state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase

      if (push_xfer) begin
        mem_cnt_q <= mem_cnt_q + CNT_W'(1);
      end else if (capture) begin
        mem_cnt_q <= mem_cnt_q - CNT_W'(1);
      end

      if (capture) begin
        pop_valid_q <= 1'b1;
        pop_data_q  <= MEM_DOUT;
      end else if (pop_xfer) begin
        pop_valid_q <= 1'b0;
      end
    end
  end

  ptr_wrap #(.WIDTH(ADDR_WIDTH), .SIZE(MEM_SIZE)) u_wr_ptr (
    .CLK   (CLK),
    .RST   (RST),
    .inc_i (push_xfer),
    .ptr_o (wr_ptr)
  );

  ptr_wrap #(.WIDTH(ADDR_WIDTH), .SIZE(MEM_SIZE)) u_rd_ptr (
    .CLK   (CLK),
    .RST   (RST),
    .inc_i (capture),
    .ptr_o (rd_ptr)
  );

  assign PUSH_READY = push_ready;
  assign POP_VALID  = pop_valid_q;
  assign POP_DATA   = pop_data_q;
  assign COUNT      = mem_cnt_q + CNT_W'(pop_valid_q);
  assign EMPTY      = (COUNT == '0);
  assign FULL       = (mem_cnt_q == CNT_MAX);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural single-port RAM.
module tb_fifo_ctrl;

  logic       CLK;
  logic       RST;
  logic       PUSH_VALID;
  logic [9:0] PUSH_DATA;
  logic       PUSH_READY;
  logic       POP_VALID;
  logic [9:0] POP_DATA;
  logic       POP_READY;
  logic [7:0] MEM_ADDR;
  logic       MEM_EN;
  logic       MEM_WE;
  logic [9:0] MEM_DIN;
  logic [9:0] MEM_DOUT;
  logic       FULL;
  logic       EMPTY;
  logic [8:0] COUNT;

  logic [9:0] ram [256];

  int n_chk;
  int n_err;

  fifo_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .PUSH_VALID (PUSH_VALID),
    .PUSH_DATA  (PUSH_DATA),
    .PUSH_READY (PUSH_READY),
    .POP_VALID  (POP_VALID),
    .POP_DATA   (POP_DATA),
    .POP_READY  (POP_READY),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_EN     (MEM_EN),
    .MEM_WE     (MEM_WE),
    .MEM_DIN    (MEM_DIN),
    .MEM_DOUT   (MEM_DOUT),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .COUNT      (COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Synchronous single-port RAM, read data valid the cycle after the command.
  always @(posedge CLK) begin
    if (MEM_EN) begin
      if (MEM_WE) ram[MEM_ADDR] <= MEM_DIN;
      else        MEM_DOUT <= ram[MEM_ADDR];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one word and wait (bounded) until it is accepted.
  task automatic do_push(input logic [9:0] d, input string tag);
    int waited;
    waited = 0;
    PUSH_VALID = 1'b1;
    PUSH_DATA  = d;
    #1;
    while (!PUSH_READY && waited < 16) begin
      @(posedge CLK);
      #2;
      waited++;
    end
    chk(tag, 32'(PUSH_READY), 32'd1);
    tick();
    PUSH_VALID = 1'b0;
  endtask

  // Wait (bounded) for POP_VALID and check the head word.
  task automatic wait_pop(input logic [9:0] d, input string tag);
    int waited;
    waited = 0;
    #1;
    while (!POP_VALID && waited < 16) begin
      @(posedge CLK);
      #2;
      waited++;
    end
    chk({tag, "_valid"}, 32'(POP_VALID), 32'd1);
    chk({tag, "_data"}, 32'(POP_DATA), 32'(d));
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    RST        = 1'b0;
    PUSH_VALID = 1'b0;
    PUSH_DATA  = '0;
    POP_READY  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_push_ready", 32'(PUSH_READY), 32'd0);
    chk("rst_pop_valid",  32'(POP_VALID),  32'd0);
    chk("rst_pop_data",   32'(POP_DATA),   32'd0);
    chk("rst_empty",      32'(EMPTY),      32'd1);
    chk("rst_full",       32'(FULL),       32'd0);
    chk("rst_count",      32'(COUNT),      32'd0);
    chk("rst_mem_en",     32'(MEM_EN),     32'd0);
    RST = 1'b1;
    tick();

    // Single push 0x155: write at addr 0, visible three edges later
    PUSH_VALID = 1'b1;
    PUSH_DATA  = 10'h155;
    #1;
    chk("p1_ready", 32'(PUSH_READY), 32'd1);
    chk("p1_we",    32'(MEM_WE),     32'd1);
    chk("p1_addr",  32'(MEM_ADDR),   32'd0);
    chk("p1_din",   32'(MEM_DIN),    32'h155);
    tick();
    PUSH_VALID = 1'b0;
    #1;
    chk("p1_cnt_n1",   32'(COUNT),     32'd1);
    chk("p1_valid_n1", 32'(POP_VALID), 32'd0);
    tick();
    chk("p1_issue_en", 32'(MEM_EN),   32'd1);
    chk("p1_issue_we", 32'(MEM_WE),   32'd0);
    chk("p1_issue_pr", 32'(PUSH_READY), 32'd0);
    tick();
    chk("p1_valid_n2", 32'(POP_VALID), 32'd0);
    tick();
    chk("p1_valid_n3", 32'(POP_VALID), 32'd1);
    chk("p1_data_n3",  32'(POP_DATA),  32'h155);
    chk("p1_count_n3", 32'(COUNT),     32'd1);
    chk("p1_empty_n3", 32'(EMPTY),     32'd0);
    POP_READY = 1'b1;
    tick();
    POP_READY = 1'b0;
    chk("p1_pop_valid", 32'(POP_VALID), 32'd0);
    chk("p1_pop_empty", 32'(EMPTY),     32'd1);

    // Fill: 257 words (one in the output register, 256 in memory)
    for (int i = 0; i < 257; i++) begin
      do_push(10'(i), "fill_accept");
    end
    #1;
    chk("fill_full",  32'(FULL),  32'd1);
    chk("fill_count", 32'(COUNT), 32'd257);
    PUSH_VALID = 1'b1;
    PUSH_DATA  = 10'h3FF;
    #1;
    chk("full_push_ready", 32'(PUSH_READY), 32'd0);
    chk("full_mem_we",     32'(MEM_WE),     32'd0);
    chk("full_mem_en",     32'(MEM_EN),     32'd0);
    tick();
    chk("full_count_kept", 32'(COUNT), 32'd257);
    PUSH_VALID = 1'b0;

    // Drain in order across the read-pointer wrap
    POP_READY = 1'b1;
    for (int i = 0; i < 257; i++) begin
      wait_pop(10'(i), "drain");
      if (i == 5) chk("drain_pr_rd_start", 32'(PUSH_READY), 32'd0);
      tick();
    end
    POP_READY = 1'b0;
    #1;
    chk("drain_empty", 32'(EMPTY), 32'd1);
    chk("drain_count", 32'(COUNT), 32'd0);
    chk("drain_full",  32'(FULL),  32'd0);

    // Arbitration: two words held, push and pop requested together
    do_push(10'h011, "arb_a");
    do_push(10'h022, "arb_b");
    wait_pop(10'h011, "arb_head_a");
    chk("arb_count2", 32'(COUNT), 32'd2);
    PUSH_VALID = 1'b1;
    PUSH_DATA  = 10'h033;
    POP_READY  = 1'b1;
    #1;
    chk("arb_s0_pr", 32'(PUSH_READY), 32'd0);
    tick();
    chk("arb_s1_pr",   32'(PUSH_READY), 32'd0);
    chk("arb_s1_en",   32'(MEM_EN),     32'd1);
    chk("arb_s1_we",   32'(MEM_WE),     32'd0);
    chk("arb_s1_addr", 32'(MEM_ADDR),   32'd3);
    chk("arb_s1_pv",   32'(POP_VALID),  32'd0);
    tick();
    chk("arb_s2_pr", 32'(PUSH_READY), 32'd0);
    tick();
    chk("arb_s3_pv",   32'(POP_VALID),  32'd1);
    chk("arb_s3_pd",   32'(POP_DATA),   32'h022);
    chk("arb_s3_pr",   32'(PUSH_READY), 32'd1);
    chk("arb_s3_we",   32'(MEM_WE),     32'd1);
    chk("arb_s3_addr", 32'(MEM_ADDR),   32'd4);
    tick();
    PUSH_VALID = 1'b0;
    #1;
    chk("arb_s4_pv",    32'(POP_VALID), 32'd0);
    chk("arb_s4_count", 32'(COUNT),     32'd1);
    wait_pop(10'h033, "arb_c");
    tick();
    POP_READY = 1'b0;
    #1;
    chk("arb_empty", 32'(EMPTY), 32'd1);

    // Reset asserted during RD_CAPTURE
    do_push(10'h077, "rc_push");
    tick();
    tick();
    chk("rc_pre_en", 32'(MEM_EN), 32'd1);
    RST = 1'b0;
    #1;
    chk("rc_mem_en", 32'(MEM_EN),     32'd0);
    chk("rc_pv",     32'(POP_VALID),  32'd0);
    chk("rc_count",  32'(COUNT),      32'd0);
    chk("rc_empty",  32'(EMPTY),      32'd1);
    chk("rc_pr",     32'(PUSH_READY), 32'd0);
    tick();
    chk("rc_hold_pv", 32'(POP_VALID), 32'd0);
    RST = 1'b1;
    tick();
    PUSH_VALID = 1'b1;
    PUSH_DATA  = 10'h0AA;
    #1;
    chk("rc_post_we",   32'(MEM_WE),   32'd1);
    chk("rc_post_addr", 32'(MEM_ADDR), 32'd0);
    chk("rc_post_din",  32'(MEM_DIN),  32'h0AA);
    tick();
    PUSH_VALID = 1'b0;
    tick();
    tick();
    tick();
    chk("rc_post_pv", 32'(POP_VALID), 32'd1);
    chk("rc_post_pd", 32'(POP_DATA),  32'h0AA);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
